serial_right_shifter: RTL and testbench

- Multi-cycle right shifter, the counterpart of the datapath's combinational left shifts.
- Serves SRL/SRA (and optional ROR) for the multi-cycle ALU extension.
- Processes STEP bits per clock under a Start/Done handshake, which keeps a 32-bit barrel shifter off the critical path.
- Sits beside the ALU. The control unit issues Start and stalls the PC until Done.

---
 rtl/shifter_pkg.sv | 18 +
 rtl/shift_step_unit.sv | 21 ++
 rtl/serial_right_shifter.sv | 107 ++++++++++
 tb/tb_serial_right_shifter.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/shifter_pkg.sv
// shifter_pkg: state encoding and STEP legality check shared by the serial right shifter.
package shifter_pkg;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = S_IDLE,
        SHIFT = S_SHIFT,
        DONE  = S_DONE
    } state_t;

    function automatic bit step_legal(int step);
        return step == 1 || step == 2 || step == 4 || step == 8;
    endfunction

endpackage

// File: rtl/shift_step_unit.sv
// shift_step_unit: one shift step, moves work right by k (0..STEP) bits.
// Vacated bits take fill, or the bits shifted out when rotating.
module shift_step_unit #(
    parameter int WIDTH = 32,
    parameter int KW    = 1
) (
    input  logic [WIDTH-1:0] work,
    input  logic             fill,
    input  logic [KW-1:0]    k,
    input  logic             rotate,
    output logic [WIDTH-1:0] next_work
);

    logic [WIDTH-1:0] hi;

    always_comb begin
        hi        = rotate ? work : {WIDTH{fill}};
        next_work = WIDTH'({hi, work} >> k);
    end

endmodule

// File: rtl/serial_right_shifter.sv
// serial_right_shifter: multi-cycle SRL/SRA, STEP bits per clock, Start/Done handshake.
// Define SERIAL_SHIFTER_ROTATE_EN to add the Rotate port (rotate right).
module serial_right_shifter
    import shifter_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int STEP    = 1,
    parameter int SHAMT_W = 5
) (
    input  logic               CLK,
    input  logic               Reset,
    input  logic               Start,
    input  logic [WIDTH-1:0]   InputData,
    input  logic [SHAMT_W-1:0] ShiftAmt,
    input  logic               Arith,
`ifdef SERIAL_SHIFTER_ROTATE_EN
    input  logic               Rotate,
`endif
    output logic               Busy,
    output logic               Done,
    output logic [WIDTH-1:0]   OutputData
);

    localparam int KW = $clog2(STEP + 1);

    if (!step_legal(STEP)) begin : g_bad_step
        $error("STEP must be 1, 2, 4 or 8");
    end
    if (SHAMT_W != $clog2(WIDTH)) begin : g_bad_shamt
        $error("SHAMT_W must equal clog2(WIDTH)");
    end

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [SHAMT_W-1:0] rem_q, rem_d;
    logic               fill_q, fill_d;
    logic [WIDTH-1:0]   out_q, out_d;
    logic               rot_q;
    logic [KW-1:0]      k;
    logic [WIDTH-1:0]   next_work;

`ifdef SERIAL_SHIFTER_ROTATE_EN
    logic rot_d;

    always_ff @(posedge CLK or posedge Reset)
        if (Reset) rot_q <= 1'b0;
        else       rot_q <= rot_d;

    always_comb rot_d = (state_q != SHIFT && Start) ? Rotate : rot_q;
`else
    assign rot_q = 1'b0;
`endif

    shift_step_unit #(.WIDTH(WIDTH), .KW(KW)) u_step (
        .work      (work_q),
        .fill      (fill_q),
        .k         (k),
        .rotate    (rot_q),
        .next_work (next_work)
    );

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            work_q  <= '0;
            rem_q   <= '0;
            fill_q  <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            rem_q   <= rem_d;
            fill_q  <= fill_d;
            out_q   <= out_d;
        end
    end

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        rem_d   = rem_q;
        fill_d  = fill_q;
        out_d   = out_q;
        k       = (rem_q < SHAMT_W'(STEP)) ? KW'(rem_q) : KW'(STEP);
        if (state_q == SHIFT) begin
            work_d = next_work;
            rem_d  = rem_q - SHAMT_W'(k);
            if (rem_q <= SHAMT_W'(STEP)) begin
                out_d   = next_work;
                state_d = DONE;
            end
        end else if (Start) begin
            work_d  = InputData;
            rem_d   = ShiftAmt;
            fill_d  = Arith & InputData[WIDTH-1];
            state_d = (ShiftAmt != '0) ? SHIFT : DONE;
            out_d   = (ShiftAmt == '0) ? InputData : out_q;
        end else begin
            state_d = IDLE;
        end
    end

    assign Busy       = (state_q == SHIFT);
    assign Done       = (state_q == DONE);
    assign OutputData = out_q;

endmodule

// File: tb/tb_serial_right_shifter.sv
// tb_serial_right_shifter: drives a STEP=1 and a STEP=4 shifter against an arithmetic reference.
module tb_serial_right_shifter;

`ifdef SERIAL_SHIFTER_ROTATE_EN
    localparam bit ROT_EN = 1'b1;
`else
    localparam bit ROT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start1 = 1'b0, start4 = 1'b0;
    logic [31:0] in_data = '0;
    logic [4:0]  in_amt = '0;
    logic        in_arith = 1'b0, in_rot = 1'b0;
    logic        busy1, done1, busy4, done4;
    logic [31:0] out1, out4;

    int          checks = 0, failures = 0;
    bit          sel;
    logic [31:0] exp_out;
    int          lat;
    logic [31:0] prev [2];

    always #5 clk = ~clk;

    serial_right_shifter #(.WIDTH(32), .STEP(1), .SHAMT_W(5)) dut1 (
        .CLK(clk), .Reset(rst), .Start(start1), .InputData(in_data), .ShiftAmt(in_amt),
        .Arith(in_arith),
`ifdef SERIAL_SHIFTER_ROTATE_EN
        .Rotate(in_rot),
`endif
        .Busy(busy1), .Done(done1), .OutputData(out1)
    );

    serial_right_shifter #(.WIDTH(32), .STEP(4), .SHAMT_W(5)) dut4 (
        .CLK(clk), .Reset(rst), .Start(start4), .InputData(in_data), .ShiftAmt(in_amt),
        .Arith(in_arith),
`ifdef SERIAL_SHIFTER_ROTATE_EN
        .Rotate(in_rot),
`endif
        .Busy(busy4), .Done(done4), .OutputData(out4)
    );

    wire        o_busy = sel ? busy4 : busy1;
    wire        o_done = sel ? done4 : done1;
    wire [31:0] o_out  = sel ? out4 : out1;

    function automatic logic [31:0] model(logic [31:0] d, int a, bit ar, bit ro);
        logic [63:0] dd;
        dd = {d, d} >> a;
        if (ro) return dd[31:0];
        if (ar) return 32'($signed(d) >>> a);
        return d >> a;
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Caller sits at a negedge; Start is sampled at the next rising edge.
    task automatic issue(bit s, logic [31:0] d, logic [4:0] a, bit ar, bit ro);
        int step;
        step     = s ? 4 : 1;
        sel      = s;
        in_data  = d;
        in_amt   = a;
        in_arith = ar;
        in_rot   = ro;
        start1   = !s;
        start4   = s;
        exp_out  = model(d, int'(a), ar, ro && ROT_EN);
        lat      = (a == 0) ? 1 : (int'(a) + step - 1) / step + 1;
    endtask

    task automatic track(string tag, bit chain, bit ign);
        int e, de, bc;
        bit hold;
        @(posedge clk);
        e = 1; de = 0; bc = 0; hold = 1'b1;
        while (de == 0 && e <= 40) begin
            @(negedge clk);
            start1   = 1'b0;
            start4   = 1'b0;
            in_data  = $urandom;
            in_amt   = 5'($urandom);
            in_arith = 1'($urandom);
            in_rot   = 1'($urandom);
            if (ign && e == 3) begin
                start1 = !sel;
                start4 = sel;
            end
            if (o_busy) bc++;
            if (o_done) de = e;
            else if (o_out !== prev[sel]) hold = 1'b0;
            if (de == 0) begin
                @(posedge clk);
                e++;
            end
        end
        check({tag, "_done_edge"}, 32'(de), 32'(lat));
        check({tag, "_out"}, o_out, exp_out);
        check({tag, "_busy_cycles"}, 32'(bc), 32'(lat - 1));
        check({tag, "_hold"}, 32'(hold), 32'd1);
        prev[sel] = exp_out;
        if (!chain) begin
            @(negedge clk);
            check({tag, "_done_pulse"}, {30'd0, o_done, o_busy}, 32'd0);
        end
    endtask

    initial begin
        logic [31:0] d;
        logic [4:0]  a;
        bit          ar, ro;
        int          dc;
        prev[0] = '0;
        prev[1] = '0;
        @(negedge clk);
        check("reset_state1", {out1[29:0], busy1, done1}, 32'd0);
        check("reset_state4", {out4[29:0], busy4, done4}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        issue(0, 32'hF000_000F, 5'd4, 0, 0);
        track("srl_step1", 0, 0);
        issue(1, 32'h8000_0010, 5'd31, 1, 0);
        track("sra_step4", 0, 0);
        issue(0, 32'h1234_5678, 5'd0, 0, 0);
        track("zero_amt1", 0, 0);
        issue(1, 32'h9ABC_DEF0, 5'd0, 1, 0);
        track("zero_amt4", 0, 0);
        issue(0, 32'hA5A5_0F0F, 5'd8, 1, 0);
        track("ignored_start", 0, 1);
        issue(1, 32'hF00D_BEEF, 5'd3, 1, 0);
        track("edge_amt_lt_step", 0, 0);

        issue(0, 32'h8765_4321, 5'd5, 1, 0);
        track("b2b_a", 1, 0);
        issue(0, 32'h0000_FFFF, 5'd2, 0, 0);
        track("b2b_b", 1, 0);
        issue(0, 32'hDEAD_0000, 5'd0, 0, 0);
        track("b2b_c", 0, 0);
        issue(1, 32'h8000_0001, 5'd9, 1, 0);
        track("b2b4_a", 1, 0);
        issue(1, 32'h4000_0000, 5'd30, 1, 0);
        track("b2b4_b", 0, 0);

`ifdef SERIAL_SHIFTER_ROTATE_EN
        issue(0, 32'h0000_0001, 5'd1, 0, 1);
        track("rotate1", 0, 0);
        issue(1, 32'h1234_5678, 5'd7, 1, 1);
        track("rotate4", 0, 0);
`endif

        for (int i = 0; i < 24; i++) begin
            d  = $urandom;
            a  = 5'($urandom);
            ar = 1'($urandom);
            ro = ROT_EN && 1'($urandom);
            issue(1'(i % 2), d, a, ar, ro);
            track("random", 1'($urandom), 0);
        end

        @(negedge clk);
        issue(0, 32'h8000_0000, 5'd20, 1, 0);
        in_data = 32'h8000_0000;
        start4  = 1'b1;
        repeat (5) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("reset_mid1", {out1[29:0], busy1, done1}, 32'd0);
        check("reset_mid4", {out4[29:0], busy4, done4}, 32'd0);
        @(negedge clk);
        start1 = 1'b0;
        start4 = 1'b0;
        rst    = 1'b0;
        dc = 0;
        repeat (30) begin
            @(negedge clk);
            if (done1 || done4) dc++;
        end
        check("no_done_after_reset", 32'(dc), 32'd0);
        prev[0] = '0;
        prev[1] = '0;
        issue(0, 32'hC000_0003, 5'd1, 1, 0);
        track("after_reset", 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
